// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU operation codes, datapath mux selects and FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'b00,
    ALU_CLS_SUB   = 2'b01,
    ALU_CLS_FUNCT = 2'b10
  } alu_cls_e;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_RTYPE_EX = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11
  } state_e;

  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-to-datapath bundle: IR fields and zero flag in, ALU op, mux
// selects and write strobes out.
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] operation;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output operation, alu_src_a, alu_src_b, i_or_d, ir_write, mem_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_en, illegal, state
  );

  modport slave (
    output opcode, funct, zero,
    input  operation, alu_src_a, alu_src_b, i_or_d, ir_write, mem_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_en, illegal, state
  );
endinterface

// File: rtl/mips_mc_control_alu_decoder.sv
// ALU decoder: maps an operation class plus funct field to the 3-bit ALU op.
// Kept separate so a pipelined datapath can reuse it.
module alu_decoder
  import mips_pkg::*;
(
  input  alu_cls_e   alu_cls,
  input  logic [5:0] funct,
  output logic [2:0] operation
);

  always_comb begin
    operation = ALU_ADD;
    case (alu_cls)
      ALU_CLS_SUB: operation = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct)
          FN_ADD:  operation = ALU_ADD;
          FN_SUB:  operation = ALU_SUB;
          FN_AND:  operation = ALU_AND;
          FN_OR:   operation = ALU_OR;
          FN_SLT:  operation = ALU_SLT;
          default: operation = ALU_ADD;
        endcase
      end
      default: operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXECUTE/MEM/WB).
// Define MIPS_MC_ADDI_EN to add the ADDI_EX/ADDI_WB states for opcode 001000.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mips_mc_control_if.master  bus
);

  state_e     state_q, state_d;
  logic       is_load_q, is_load_d;

  alu_cls_e   alu_cls;
  logic [2:0] alu_operation;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       branch;
  logic       illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d    = ST_FETCH;
    is_load_d  = is_load_q;
    alu_cls    = ALU_CLS_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;

    if (reset) begin
      // Fetch-shaped mux settings, but no strobe may fire while reset is held.
      alu_src_b = SRCB_FOUR;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ir_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
          state_d   = ST_DECODE;
        end
        ST_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          // lw/sw choice is latched here so MEMADR never looks at the IR.
          is_load_d = (bus.opcode == OP_LW);
          case (bus.opcode)
            OP_LW, OP_SW: state_d = ST_MEMADR;
            OP_RTYPE: begin
              if (funct_supported(bus.funct)) state_d = ST_RTYPE_EX;
              else                            illegal = 1'b1;
            end
            OP_BEQ: state_d = ST_BRANCH;
            OP_J:   state_d = ST_JUMP;
`ifdef MIPS_MC_ADDI_EN
            OP_ADDI: state_d = ST_ADDI_EX;
`endif
            default: illegal = 1'b1;
          endcase
        end
        ST_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = is_load_q ? ST_MEMRD : ST_MEMWR;
        end
        ST_MEMRD: begin
          i_or_d  = 1'b1;
          state_d = ST_MEMWB;
        end
        ST_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        ST_MEMWR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        ST_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_cls   = ALU_CLS_FUNCT;
          state_d   = ST_RTYPE_WB;
        end
        ST_RTYPE_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = 1'b1;
          alu_cls   = ALU_CLS_SUB;
          pc_src    = PCSRC_ALUOUT;
          branch    = 1'b1;
        end
        ST_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
`ifdef MIPS_MC_ADDI_EN
        ST_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = ST_ADDI_WB;
        end
        ST_ADDI_WB: begin
          reg_write = 1'b1;
        end
`endif
        default: state_d = ST_FETCH;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_cls   (alu_cls),
    .funct     (bus.funct),
    .operation (alu_operation)
  );

  assign bus.operation  = alu_operation;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.i_or_d     = i_or_d;
  assign bus.ir_write   = ir_write;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.pc_src     = pc_src;
  assign bus.pc_en      = pc_write | (branch & bus.zero);
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control: each instruction is expanded into its
// expected per-cycle output sequence by a reference model and compared cycle by cycle.
module tb_mips_mc_control;
  import mips_pkg::*;

`ifdef MIPS_MC_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] op;
    logic       a;
    logic [1:0] b;
    logic       iord;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic [1:0] pcs;
    logic       pce;
    logic       ill;
  } obs_t;

  typedef enum {K_FETCH, K_DECODE, K_DECODE_ILL, K_MEMADR, K_MEMRD, K_MEMWB,
                K_MEMWR, K_REX, K_RWB, K_BR, K_J, K_AEX, K_AWB} step_e;

  step_e seq[$];

  function automatic bit legal_funct(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] rtype_op(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle of an instruction; unlisted fields 0, op add.
  function automatic obs_t model(input step_e k, input logic z, input logic [5:0] fn);
    obs_t e;
    e = '0;
    e.op = 3'b010;
    case (k)
      K_FETCH:      begin e.st = ST_FETCH; e.b = 2'b01; e.irw = 1'b1; e.pce = 1'b1; end
      K_DECODE:     begin e.st = ST_DECODE; e.b = 2'b11; end
      K_DECODE_ILL: begin e.st = ST_DECODE; e.b = 2'b11; e.ill = 1'b1; end
      K_MEMADR:     begin e.st = ST_MEMADR; e.a = 1'b1; e.b = 2'b10; end
      K_MEMRD:      begin e.st = ST_MEMRD; e.iord = 1'b1; end
      K_MEMWB:      begin e.st = ST_MEMWB; e.m2r = 1'b1; e.rw = 1'b1; end
      K_MEMWR:      begin e.st = ST_MEMWR; e.iord = 1'b1; e.mw = 1'b1; end
      K_REX:        begin e.st = ST_RTYPE_EX; e.a = 1'b1; e.op = rtype_op(fn); end
      K_RWB:        begin e.st = ST_RTYPE_WB; e.rd = 1'b1; e.rw = 1'b1; end
      K_BR:         begin e.st = ST_BRANCH; e.a = 1'b1; e.op = 3'b110; e.pcs = 2'b01; e.pce = z; end
      K_J:          begin e.st = ST_JUMP; e.pcs = 2'b10; e.pce = 1'b1; end
      K_AEX:        begin e.st = ST_ADDI_EX; e.a = 1'b1; e.b = 2'b10; end
      K_AWB:        begin e.st = ST_ADDI_WB; e.rw = 1'b1; end
      default:      e.st = ST_FETCH;
    endcase
    return e;
  endfunction

  function automatic void build(input logic [5:0] op, input logic [5:0] fn);
    seq.delete();
    seq.push_back(K_FETCH);
    case (op)
      6'b100011: begin seq.push_back(K_DECODE); seq.push_back(K_MEMADR);
                       seq.push_back(K_MEMRD); seq.push_back(K_MEMWB); end
      6'b101011: begin seq.push_back(K_DECODE); seq.push_back(K_MEMADR);
                       seq.push_back(K_MEMWR); end
      6'b000000: begin
        if (legal_funct(fn)) begin
          seq.push_back(K_DECODE); seq.push_back(K_REX); seq.push_back(K_RWB);
        end else seq.push_back(K_DECODE_ILL);
      end
      6'b000100: begin seq.push_back(K_DECODE); seq.push_back(K_BR); end
      6'b000010: begin seq.push_back(K_DECODE); seq.push_back(K_J); end
      6'b001000: begin
        if (ADDI_EN) begin
          seq.push_back(K_DECODE); seq.push_back(K_AEX); seq.push_back(K_AWB);
        end else seq.push_back(K_DECODE_ILL);
      end
      default: seq.push_back(K_DECODE_ILL);
    endcase
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.st = bus.state;      o.op = bus.operation;  o.a = bus.alu_src_a;
    o.b = bus.alu_src_b;   o.iord = bus.i_or_d;   o.irw = bus.ir_write;
    o.mw = bus.mem_write;  o.rw = bus.reg_write;  o.rd = bus.reg_dst;
    o.m2r = bus.mem_to_reg; o.pcs = bus.pc_src;   o.pce = bus.pc_en;
    o.ill = bus.illegal;
    return o;
  endfunction

  // Called just after a rising edge; zmode -1 = random zero, else forced.
  // abort_at >= 0 asserts reset during that step of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at);
    obs_t exp;
    obs_t rexp;
    bus.opcode = op;
    bus.funct  = fn;
    build(op, fn);
    for (int i = 0; i < seq.size(); i++) begin
      bus.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (i == abort_at) reset = 1'b1;
      @(negedge clk);
      exp = model(seq[i], bus.zero, fn);
      if (reset) begin
        rexp = model(K_FETCH, 1'b0, fn);
        rexp.st = exp.st;
        rexp.irw = 1'b0; rexp.pce = 1'b0;
        exp = rexp;
      end
      chk($sformatf("op%02h fn%02h step%0d%s", op, fn, i, reset ? " rst" : ""),
          32'(observed()), 32'(exp));
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        return;
      end
    end
  endtask

  logic [5:0] legal_ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
  logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t rexp;
    logic [5:0] op, fn;
    int ab;

    reset = 1'b1;
    bus.opcode = 6'b0;
    bus.funct  = 6'b0;
    bus.zero   = 1'b0;

    @(negedge clk);
    chk("reset0 strobes", 32'({bus.ir_write, bus.mem_write, bus.reg_write, bus.pc_en, bus.illegal}), 32'd0);
    @(posedge clk);
    #1;
    bus.zero = 1'b1;
    @(negedge clk);
    rexp = model(K_FETCH, 1'b0, 6'b0);
    rexp.irw = 1'b0; rexp.pce = 1'b0;
    chk("reset1 outputs", 32'(observed()), 32'(rexp));
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(6'b000000, 6'b101010, -1, -1);
    run_instr(6'b100011, 6'b000000, -1, -1);
    run_instr(6'b101011, 6'b000000, -1, -1);
    run_instr(6'b000100, 6'b000000,  1, -1);
    run_instr(6'b000100, 6'b000000,  0, -1);
    run_instr(6'b000010, 6'b000000, -1, -1);
    run_instr(6'b111111, 6'b000000, -1, -1);
    run_instr(6'b000000, 6'b000111, -1, -1);
    run_instr(6'b001000, 6'b010101, -1, -1);
    run_instr(6'b101011, 6'b000000, -1, 3);
    run_instr(6'b100011, 6'b000000, -1, 4);
    run_instr(6'b000000, 6'b100010, -1, -1);

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 4)];
      build(op, fn);
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1;
      run_instr(op, fn, -1, ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
